fc_readout: RTL and testbench

- Downstream stage of the fully-connected process unit. After accumulation completes, it drains every neuron accumulator through the unit's read port.
- Adds a per-neuron bias with signed saturation, optionally applies ReLU, and buffers the results in a small FIFO.
- Streams results to the next layer over a valid/ready handshake, with a last flag on the final neuron.

---
 rtl/fc_readout_if.sv | 12 +
 rtl/fc_readout.sv | 159 +++++++++++++++
 tb/tb_fc_readout.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_readout_if.sv
// Output stream of fc_readout: result word, last-neuron flag and valid/ready handshake.
interface fc_readout_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/fc_readout.sv
// Drains FC accumulators, adds per-neuron bias with saturation, buffers results in a FIFO.
// Optional macro FC_RELU_EN clamps negative saturated results to zero before buffering.
module fc_readout #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC        = 5,
  parameter int NUM_NEURONS = 4,
  parameter int ADDR_WIDTH  = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pu_own,
  output logic                  pu_read_en,
  output logic [ADDR_WIDTH-1:0] pu_addr,
  input  logic [DATA_WIDTH-1:0] pu_result,
  input  logic                  bias_wr_en,
  input  logic [ADDR_WIDTH-1:0] bias_wr_addr,
  input  logic [DATA_WIDTH-1:0] bias_wr_data,
  fc_readout_if.master          out_if
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_NEURONS - 1);

  // Bias shares the accumulator Q format, so FRAC only constrains legal configurations.
  if (NUM_NEURONS > 2**ADDR_WIDTH || FRAC >= DATA_WIDTH) begin : g_bad_cfg
    $error("fc_readout: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_inflight;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_bias [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                  r_mem_last [FIFO_DEPTH];
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [CW-1:0]         r_count;

  logic                  w_busy;
  logic                  w_issue;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_last_pop;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_sat;
  logic [DATA_WIDTH-1:0] w_res;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ISSUE;
      S_ISSUE: if (w_issue && r_idx == LAST_IDX) w_next = S_DRAIN;
      S_DRAIN: if (w_last_pop) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Room check counts the read still in flight so a full FIFO is never overrun.
  always_comb begin
    w_busy  = (r_state != S_IDLE);
    w_issue = (r_state == S_ISSUE) &&
              ((r_count + CW'(r_inflight)) < CW'(FIFO_DEPTH));
  end

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & out_if.out_ready;
  assign w_last_pop = (r_state == S_DRAIN) && w_pop && r_mem_last[r_rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= w_last_pop;
      if (r_state == S_IDLE && start) begin
        r_idx <= '0;
      end else if (w_issue) begin
        r_idx  <= r_idx + 1'b1;
        r_addr <= r_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2**ADDR_WIDTH; i++) r_bias[i] <= '0;
    end else if (bias_wr_en) begin
      r_bias[bias_wr_addr] <= bias_wr_data;
    end
  end

  // r_addr still names the in-flight read while its result is on pu_result.
  always_comb begin
    w_sum = {pu_result[DATA_WIDTH-1], pu_result} +
            {r_bias[r_addr][DATA_WIDTH-1], r_bias[r_addr]};
    if (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1])
      w_sat = w_sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      w_sat = w_sum[DATA_WIDTH-1:0];
`ifdef FC_RELU_EN
    w_res = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
    w_res = w_sat;
`endif
  end

  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_mem[r_wp]      <= w_res;
      r_mem_last[r_wp] <= (r_addr == LAST_IDX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (r_inflight) r_wp <= r_wp + 1'b1;
      if (w_pop)      r_rp <= r_rp + 1'b1;
      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign busy       = w_busy;
  assign pu_own     = w_busy;
  assign done       = r_done;
  assign pu_read_en = w_issue;
  assign pu_addr    = w_issue ? r_idx : r_addr;

  assign out_if.out_valid = w_valid;
  assign out_if.out_data  = w_valid ? r_mem[r_rp] : '0;
  assign out_if.out_last  = w_valid & r_mem_last[r_rp];

endmodule

// File: tb/tb_fc_readout.sv
// Scoreboard bench for fc_readout: random frames against an integer bias/saturation model.
module tb_fc_readout;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NN = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, pu_own, pu_read_en;
  logic [AW-1:0] pu_addr;
  logic [DW-1:0] pu_result = '0;
  logic          bias_wr_en = 1'b0;
  logic [AW-1:0] bias_wr_addr = '0;
  logic [DW-1:0] bias_wr_data = '0;

  fc_readout_if #(.DATA_WIDTH(DW)) u_if ();

  fc_readout #(
    .DATA_WIDTH(DW), .FRAC(5), .NUM_NEURONS(NN), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pu_own(pu_own),
    .pu_read_en(pu_read_en), .pu_addr(pu_addr), .pu_result(pu_result),
    .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
    .out_if(u_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] acc [2**AW];
  logic [DW-1:0] bias_m [NN];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_done = 0;
  int            n_reads = 0;
  int            ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 2**(DW-1) - 1) s = 2**(DW-1) - 1;
    if (s < -(2**(DW-1)))  s = -(2**(DW-1));
`ifdef FC_RELU_EN
    if (s < 0) s = 0;
`endif
    return DW'(s);
  endfunction

  // Process unit: registered result one cycle after the read strobe.
  always @(posedge clk) if (pu_read_en) pu_result <= acc[pu_addr];

  initial begin
    u_if.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       u_if.out_ready = 1'b1;
        1:       u_if.out_ready = 1'($urandom_range(0, 1));
        default: u_if.out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) n_done++;
    if (pu_read_en === 1'b1) n_reads++;
    if (u_if.out_valid === 1'b1 && u_if.out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_unexpected: got data %0h, scoreboard empty (t=%0t)", u_if.out_data, $time);
      end else begin
        e = q.pop_front();
        chk("out_data", 32'(u_if.out_data), 32'(e.data));
        chk("out_last", 32'(u_if.out_last), 32'(e.last));
      end
    end
  end

  task automatic push_expected();
    exp_t e;
    for (int i = 0; i < NN; i++) begin
      e.data = model(acc[i], bias_m[i]);
      e.last = (i == NN - 1);
      q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic write_bias(input int idx, input logic [DW-1:0] val);
    bias_wr_en   = 1'b1;
    bias_wr_addr = AW'(idx);
    bias_wr_data = val;
    @(posedge clk); #1;
    bias_wr_en   = 1'b0;
    bias_m[idx]  = val;
  endtask

  task automatic wait_frame(input int d0);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    @(posedge clk); #1;
    chk("frame_end_busy", 32'(busy), 32'd0);
    chk("done_pulses", 32'(n_done - d0), 32'd1);
    chk("sb_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic run_frame();
    int d0;
    d0 = n_done;
    push_expected();
    pulse_start();
    wait_frame(d0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, lat, found;
    for (int i = 0; i < 2**AW; i++) acc[i] = '0;
    for (int i = 0; i < NN; i++) bias_m[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(pu_read_en), 32'd0);
    chk("rst_addr", 32'(pu_addr), 32'd0);
    chk("rst_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_data", 32'(u_if.out_data), 32'd0);
    chk("rst_last", 32'(u_if.out_last), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame with zero bias and latency measurement.
    acc[0] = 16'd32; acc[1] = 16'hFFC0; acc[2] = 16'd100; acc[3] = 16'd0;
    d0 = n_done;
    push_expected();
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("pu_own_eq_busy", 32'(pu_own), 32'd1);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      if (u_if.out_valid === 1'b1) begin lat = n; break; end
      @(posedge clk); #1;
    end
    chk("first_valid_latency", 32'(lat), 32'd3);
    wait_frame(d0);

    // Saturation at both rails.
    write_bias(0, 16'h0200);
    write_bias(1, 16'hFE00);
    write_bias(3, 16'h7FFF);
    acc[0] = 16'h7F00; acc[1] = 16'h8100; acc[2] = 16'h1234; acc[3] = 16'h8000;
    ready_mode = 1;
    run_frame();

    // Downstream stall: FIFO fills, reads stop, head stays put.
    ready_mode = 2;
    @(posedge clk); #1;
    for (int i = 0; i < NN; i++) acc[i] = DW'($urandom);
    d0 = n_done;
    r0 = n_reads;
    push_expected();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i >= 5) chk("stall_head", 32'(u_if.out_data), 32'(q[0].data));
    end
    chk("stall_reads", 32'(n_reads - r0), 32'(FD));
    chk("stall_rd_en_idle", 32'(pu_read_en), 32'd0);
    chk("stall_valid", 32'(u_if.out_valid), 32'd1);
    ready_mode = 0;
    wait_frame(d0);

    // Reset during ISSUE aborts the frame; bias table returns to zero.
    d0 = n_done;
    push_expected();
    pulse_start();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    for (int i = 0; i < NN; i++) bias_m[i] = '0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(u_if.out_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("abort_no_done", 32'(n_done - d0), 32'd0);
    chk("abort_still_empty", 32'(u_if.out_valid), 32'd0);
    run_frame();

    // Bias write racing the capture of index 2 uses the old value.
    write_bias(2, 16'd10);
    acc[0] = 16'd1; acc[1] = 16'd2; acc[2] = 16'd3; acc[3] = 16'd4;
    d0 = n_done;
    push_expected();
    pulse_start();
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pu_read_en === 1'b1 && pu_addr == AW'(2)) begin found = 1; break; end
    end
    chk("race_issue_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    write_bias(2, 16'd500);
    wait_frame(d0);
    run_frame();

    // Randomized frames with random bias updates and backpressure.
    for (int f = 0; f < 25; f++) begin
      ready_mode = int'($urandom_range(0, 1));
      for (int i = 0; i < NN; i++) acc[i] = DW'($urandom);
      for (int w = 0; w < int'($urandom_range(0, 2)); w++)
        write_bias(int'($urandom_range(0, NN - 1)), DW'($urandom));
      run_frame();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
